bcd_display_ctrl: RTL and testbench

Sequential binary-to-BCD conversion controller for the result display path. Accepts a 32-bit value from the core/debug side over a valid/ready handshake, converts it over 32 cycles with an iterative shift-add-3 (double-dabble) engine, and holds the 10-digit result stable until the next conversion completes. It also generates the digit-scan sequence, including leading-zero blanking, for a multiplexed 10-digit display.

---
 rtl/bcd_display_ctrl_if.sv | 22 ++
 rtl/bcd_display_ctrl.sv | 141 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_ctrl_if.sv
// Request handshake bundle for the BCD display controller.
// The requester drives value/sign and holds valid until it sees ready.
interface bcd_display_ctrl_if;
    logic        req_valid;
    logic [31:0] req_data;
    logic        req_signed;
    logic        req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_signed,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_signed,
        output req_ready
    );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Iterative binary-to-BCD converter (double-dabble) with held result
// and a leading-zero-blanking scan generator for a 10-digit display.
module bcd_display_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    bcd_display_ctrl_if.slave    req,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [39:0]          o_digits,
    output logic                 o_neg,
    output logic [9:0]           o_nz_mask,
    output logic [9:0]           o_scan_en,
    output logic [3:0]           o_scan_bcd,
    output logic                 o_scan_blank
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_TC = DW'(SCAN_DIV - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] mag;
    logic [39:0] scratch;
    logic [39:0] scr_adj;
    logic [9:0]  nz_next;
    logic        sign;
    logic [4:0]  cnt;
    logic        accept;

    logic [DW-1:0] div_cnt;
    logic [3:0]    idx;
    logic [5:0]    bit_ofs;

    assign req.req_ready = (state == IDLE);
    assign o_busy        = (state == SHIFT) || (state == DONE);
    assign accept        = req.req_valid && (state == IDLE);

    always_comb begin
        scr_adj = scratch;
        for (int k = 0; k < 10; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit is significant if it or any more significant digit is nonzero.
    always_comb begin
        nz_next    = '0;
        nz_next[9] = |scratch[39:36];
        for (int k = 8; k >= 1; k--) begin
            nz_next[k] = nz_next[k+1] | (|scratch[4*k +: 4]);
        end
        nz_next[0] = 1'b1;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (cnt == 5'd31) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mag       <= '0;
            scratch   <= '0;
            sign      <= 1'b0;
            cnt       <= '0;
            o_done    <= 1'b0;
            o_digits  <= '0;
            o_neg     <= 1'b0;
            o_nz_mask <= 10'h001;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (req.req_signed && req.req_data[31]) begin
                            mag <= ~req.req_data + 32'd1;
                        end else begin
                            mag <= req.req_data;
                        end
                        sign    <= req.req_signed & req.req_data[31];
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= {scr_adj[38:0], mag[31]};
                    mag     <= {mag[30:0], 1'b0};
                    cnt     <= cnt + 5'd1;
                end
                DONE: begin
                    o_digits  <= scratch;
                    o_neg     <= sign;
                    o_nz_mask <= nz_next;
                    o_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_TC) begin
            div_cnt <= '0;
            idx     <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign bit_ofs      = {idx, 2'b00};
    assign o_scan_en    = 10'd1 << idx;
    assign o_scan_bcd   = o_digits[bit_ofs +: 4];
    assign o_scan_blank = ~o_nz_mask[idx];

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: vector table plus handshake,
// mid-conversion reset and scan sequences.
module tb_bcd_display_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_busy;
    logic        o_done;
    logic [39:0] o_digits;
    logic        o_neg;
    logic [9:0]  o_nz_mask;
    logic [9:0]  o_scan_en;
    logic [3:0]  o_scan_bcd;
    logic        o_scan_blank;

    bcd_display_ctrl_if req();

    bcd_display_ctrl #(.SCAN_DIV(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .req          (req.slave),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_digits     (o_digits),
        .o_neg        (o_neg),
        .o_nz_mask    (o_nz_mask),
        .o_scan_en    (o_scan_en),
        .o_scan_bcd   (o_scan_bcd),
        .o_scan_blank (o_scan_blank)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic [39:0] digits;
        logic        neg;
        logic [9:0]  mask;
    } vec_t;

    vec_t vecs[10];
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ready"}, 64'(req.req_ready), 64'd1);
        chk({tag, " busy"}, 64'(o_busy), 64'd0);
        chk({tag, " done"}, 64'(o_done), 64'd0);
        chk({tag, " digits"}, 64'(o_digits), 64'd0);
        chk({tag, " neg"}, 64'(o_neg), 64'd0);
        chk({tag, " mask"}, 64'(o_nz_mask), 64'h001);
        chk({tag, " scan_en"}, 64'(o_scan_en), 64'h001);
        chk({tag, " scan_bcd"}, 64'(o_scan_bcd), 64'd0);
        chk({tag, " scan_blank"}, 64'(o_scan_blank), 64'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req.req_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("wait ready", 64'(req.req_ready), 64'd1);
    endtask

    // Returns at the negedge of the o_done cycle (or after a timeout).
    task automatic run_conv(input logic [31:0] d, input logic s);
        int n;
        wait_ready();
        req.req_valid  = 1'b1;
        req.req_data   = d;
        req.req_signed = s;
        @(posedge i_clk);
        @(negedge i_clk);
        req.req_valid = 1'b0;
        chk("busy after accept", 64'(o_busy), 64'd1);
        chk("ready after accept", 64'(req.req_ready), 64'd0);
        n = 1;
        while (!o_done && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        chk("done latency", 64'(n), 64'd34);
        chk("ready in done cycle", 64'(req.req_ready), 64'd1);
    endtask

    initial begin
        int n;
        int bad;
        int ready_bad;
        logic [9:0] prev;
        logic [3:0] exp_bcd;

        n_vec = 0;
        n_err = 0;
        vecs[0] = '{32'hFFFFFFFF, 1'b0, 40'h4294967295, 1'b0, 10'h3FF};
        vecs[1] = '{32'hFFFFFF85, 1'b1, 40'h0000000123, 1'b1, 10'h007};
        vecs[2] = '{32'h80000000, 1'b1, 40'h2147483648, 1'b1, 10'h3FF};
        vecs[3] = '{32'h00000000, 1'b0, 40'h0000000000, 1'b0, 10'h001};
        vecs[4] = '{32'h80000000, 1'b0, 40'h2147483648, 1'b0, 10'h3FF};
        vecs[5] = '{32'hFFFFFFFF, 1'b1, 40'h0000000001, 1'b1, 10'h001};
        vecs[6] = '{32'd12345, 1'b0, 40'h0000012345, 1'b0, 10'h01F};
        vecs[7] = '{32'd1000000000, 1'b0, 40'h1000000000, 1'b0, 10'h3FF};
        vecs[8] = '{32'd999999999, 1'b0, 40'h0999999999, 1'b0, 10'h1FF};
        vecs[9] = '{32'd7, 1'b1, 40'h0000000007, 1'b0, 10'h001};

        req.req_valid  = 1'b0;
        req.req_data   = '0;
        req.req_signed = 1'b0;
        i_rst_n        = 1'b1;

        #22;
        i_rst_n = 1'b0;
        #1;
        chk_reset_vals("reset");
        repeat (3) @(negedge i_clk);
        chk("ready in reset", 64'(req.req_ready), 64'd1);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].data, vecs[i].sgn);
            chk($sformatf("v%0d digits", i), 64'(o_digits),
                64'(vecs[i].digits));
            chk($sformatf("v%0d neg", i), 64'(o_neg), 64'(vecs[i].neg));
            chk($sformatf("v%0d mask", i), 64'(o_nz_mask),
                64'(vecs[i].mask));
        end

        // Held request: 42 then 7 back-to-back.
        wait_ready();
        req.req_valid  = 1'b1;
        req.req_data   = 32'd42;
        req.req_signed = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        req.req_data = 32'd7;
        ready_bad = 0;
        n = 1;
        while (!o_done && n < 60) begin
            if (req.req_ready || !o_busy) ready_bad++;
            @(negedge i_clk);
            n++;
        end
        chk("hs lat1", 64'(n), 64'd34);
        chk("hs no early accept", 64'(ready_bad), 64'd0);
        chk("hs digits 42", 64'(o_digits), 64'h42);
        chk("hs ready on done", 64'(req.req_ready), 64'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        req.req_valid = 1'b0;
        chk("hs second accepted", 64'(o_busy), 64'd1);
        bad = 0;
        n = 1;
        while (!o_done && n < 60) begin
            if (o_digits !== 40'h42) bad++;
            @(negedge i_clk);
            n++;
        end
        chk("hs lat2", 64'(n), 64'd34);
        chk("hs hold 42", 64'(bad), 64'd0);
        chk("hs digits 7", 64'(o_digits), 64'h7);

        // Reset 10 cycles into a conversion.
        wait_ready();
        req.req_valid  = 1'b1;
        req.req_data   = 32'd5555;
        req.req_signed = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        req.req_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_done) bad++;
            @(negedge i_clk);
        end
        chk("midrst no done", 64'(bad), 64'd0);
        chk("midrst digits", 64'(o_digits), 64'd0);
        run_conv(32'd12345, 1'b0);
        chk("post rst digits", 64'(o_digits), 64'h12345);

        // Scan sequence over the value 123.
        run_conv(32'hFFFFFF85, 1'b1);
        chk("scan src digits", 64'(o_digits), 64'h123);
        prev = o_scan_en;
        n = 0;
        @(negedge i_clk);
        while (!(prev == 10'h200 && o_scan_en == 10'h001) && n < 100) begin
            prev = o_scan_en;
            @(negedge i_clk);
            n++;
        end
        chk("scan wrap 200->001", 64'(o_scan_en), 64'h001);
        for (int p = 0; p < 10; p++) begin
            exp_bcd = (p == 0) ? 4'd3 : (p == 1) ? 4'd2 :
                      (p == 2) ? 4'd1 : 4'd0;
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan en p%0d", p), 64'(o_scan_en),
                    64'(10'd1 << p));
                chk($sformatf("scan bcd p%0d", p), 64'(o_scan_bcd),
                    64'(exp_bcd));
                chk($sformatf("scan blank p%0d", p), 64'(o_scan_blank),
                    64'(p >= 3));
                @(negedge i_clk);
            end
        end
        chk("scan wrap again", 64'(o_scan_en), 64'h001);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
